// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer in front of
// mem_control. One command is accepted at a time. Its single ACCESS cycle is
// driven onto the memory port. For reads, the fixed memory latency is counted
// and mem_q is returned to the requester that issued the read.
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int LANES  = 16,
  parameter int RD_LAT = 2    // edges from ACCESS address to valid mem_q, 1..7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic                    vec0,
  input  logic                    vec1,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [ADDR_W-1:0]       addr1,
  input  logic [LANES-1:0][31:0]  wdata0,
  input  logic [LANES-1:0][31:0]  wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [LANES-1:0][31:0]  rdata0,
  output logic [LANES-1:0][31:0]  rdata1,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES-1:0][31:0]  mem_data,
  output logic                    mem_wren,
  output logic                    mem_vec,
  input  logic [LANES-1:0][31:0]  mem_q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT);
  localparam logic [2:0] CNT_ONE  = 3'd1;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_prio;     // 0: requester 0 wins a tie
  logic                     r_id;       // requester owning the current command
  logic                     r_we;
  logic                     r_vec;
  logic [ADDR_W-1:0]        r_addr;
  logic [LANES-1:0][31:0]   r_data;
  logic [2:0]               r_cnt;
  logic                     r_rvalid0;
  logic                     r_rvalid1;
  logic [LANES-1:0][31:0]   r_rdata0;
  logic [LANES-1:0][31:0]   r_rdata1;

  logic                     w_any_req;
  logic                     w_winner;
  logic                     w_grant;
  logic                     w_capture;
  logic                     w_sel_we;
  logic                     w_sel_vec;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [LANES-1:0][31:0]   w_sel_wdata;
  logic [LANES-1:0][31:0]   w_cmd_data;

  // Winner selection: a lone request wins outright; a tie goes to the
  // requester that was not granted last.
  assign w_any_req   = req0 | req1;
  assign w_winner    = (req0 & req1) ? r_prio : req1;
  assign w_sel_we    = w_winner ? we1    : we0;
  assign w_sel_vec   = w_winner ? vec1   : vec0;
  assign w_sel_addr  = w_winner ? addr1  : addr0;
  assign w_sel_wdata = w_winner ? wdata1 : wdata0;
  assign w_capture   = (r_state == S_WAIT) && (r_cnt == CNT_ONE);

  // Scalar stores replicate lane 0 so every bank sees the same value.
  always_comb begin
    w_cmd_data = w_sel_wdata;
    if (!w_sel_vec) begin
      for (int i = 0; i < LANES; i++) begin
        w_cmd_data[i] = w_sel_wdata[0];
      end
    end
  end

  // Next-state and grant decode.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant = 1'b1;
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:   if (r_cnt == CNT_ONE) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Latch the winning command and advance the round-robin pointer on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_id   <= 1'b0;
      r_we   <= 1'b0;
      r_vec  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_grant) begin
      r_prio <= ~w_winner;
      r_id   <= w_winner;
      r_we   <= w_sel_we;
      r_vec  <= w_sel_vec;
      r_addr <= w_sel_addr;
      r_data <= w_cmd_data;
    end
  end

  // Read latency counter: loaded in a read ACCESS, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !r_we) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Capture mem_q for the issuing requester and pulse its rvalid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_capture && !r_id;
      r_rvalid1 <= w_capture &&  r_id;
      if (w_capture && !r_id) r_rdata0 <= mem_q;
      if (w_capture &&  r_id) r_rdata1 <= mem_q;
    end
  end

  assign gnt0     = w_grant & ~w_winner;
  assign gnt1     = w_grant &  w_winner;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign busy     = (r_state != S_IDLE);
  assign mem_addr = r_addr;
  assign mem_data = r_data;
  assign mem_vec  = r_vec;
  // Combinational so an asynchronous reset removes the write strobe at once.
  assign mem_wren = (r_state == S_ACCESS) && r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural stand-in for
// mem_control (16 lanes, lane i at base+i modulo 2^ADDR_W, 16-bit storage).
module tb_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int LANES  = 16;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [LANES-1:0][31:0] lanes_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1, vec0, vec1;
  logic [ADDR_W-1:0] addr0, addr1;
  lanes_t            wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy, mem_wren, mem_vec;
  lanes_t            rdata0, rdata1, mem_data, mem_q;
  logic [ADDR_W-1:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int n_rv0 = 0, n_rv1 = 0, n_wren = 0, n_gnt_busy = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LANES(LANES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .vec0(vec0), .vec1(vec1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_vec(mem_vec), .mem_q(mem_q)
  );

  // Initial memory contents.
  function automatic logic [15:0] pat(input int a);
    return 16'((a * 3 + 7) & 16'hFFFF);
  endfunction

  // Memory stand-in: registered read pipeline of RD_LAT stages, 16-bit cells.
  logic [15:0] model_mem [0:DEPTH-1];
  lanes_t      pipe [0:RD_LAT-1];
  assign mem_q = pipe[RD_LAT-1];

  initial for (int a = 0; a < DEPTH; a++) model_mem[a] = pat(a);

  always @(posedge clk) begin : mem_model
    lanes_t            look;
    logic [ADDR_W-1:0] a;
    look = '0;
    if (mem_vec) begin
      for (int i = 0; i < LANES; i++) begin
        a = mem_addr + ADDR_W'(i);
        look[i] = {16'h0, model_mem[a]};
      end
    end else begin
      look[0] = {16'h0, model_mem[mem_addr]};
    end
    if (mem_wren) begin
      if (mem_vec) begin
        for (int i = 0; i < LANES; i++) begin
          a = mem_addr + ADDR_W'(i);
          model_mem[a] = mem_data[i][15:0];
        end
      end else begin
        model_mem[mem_addr] = mem_data[0][15:0];
      end
    end
    pipe[0] <= look;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rvalid0) n_rv0++;
    if (rvalid1) n_rv1++;
    if (mem_wren) n_wren++;
    if (busy && (gnt0 || gnt1)) n_gnt_busy++;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request until granted (bounded), then drop it. Returns at the
  // negedge of the ACCESS cycle. Must be called at posedge+1.
  task automatic issue(input int id, input logic we, input logic vec,
                       input logic [ADDR_W-1:0] addr, input lanes_t wd);
    bit ok;
    ok = 0;
    if (id == 0) begin req0 = 1; we0 = we; vec0 = vec; addr0 = addr; wdata0 = wd; end
    else         begin req1 = 1; we1 = we; vec1 = vec; addr1 = addr; wdata1 = wd; end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((id == 0) ? gnt0 : gnt1) begin ok = 1; break; end
    end
    check($sformatf("gnt%0d_seen", id), ok, 1);
    step();
    if (id == 0) req0 = 0; else req1 = 0;
    @(negedge clk);
  endtask

  // From the ACCESS-cycle negedge, count cycles (grant cycle = 0) until the
  // requester's rvalid; -1 if the bound expires. Returns at posedge+1.
  task automatic wait_rv(input int id, output int lat);
    int cyc;
    cyc = 1;
    lat = -1;
    while (cyc < 12) begin
      step();
      cyc++;
      @(negedge clk);
      if ((id == 0) ? rvalid0 : rvalid1) begin lat = cyc; break; end
    end
    step();
  endtask

  typedef struct {
    logic r0, r1;
    logic e_g0, e_g1, e_busy, e_rv0, e_rv1;
  } vec_t;

  vec_t   tbl [14];
  lanes_t exp_l, wd;
  int     lat, rv0_0, rv1_0, wr_0;

  initial begin : main
    // Contention: both requesters reading; grants alternate, rvalid routed.
    tbl[0]  = '{1,1, 1,0,0,0,0};
    tbl[1]  = '{1,1, 0,0,1,0,0};
    tbl[2]  = '{1,1, 0,0,1,0,0};
    tbl[3]  = '{1,1, 0,0,1,0,0};
    tbl[4]  = '{1,1, 0,1,0,1,0};
    tbl[5]  = '{1,1, 0,0,1,0,0};
    tbl[6]  = '{1,1, 0,0,1,0,0};
    tbl[7]  = '{1,1, 0,0,1,0,0};
    tbl[8]  = '{1,1, 1,0,0,0,1};
    tbl[9]  = '{0,0, 0,0,1,0,0};
    tbl[10] = '{0,0, 0,0,1,0,0};
    tbl[11] = '{0,0, 0,0,1,0,0};
    tbl[12] = '{0,0, 0,0,0,1,0};
    tbl[13] = '{0,0, 0,0,0,0,0};

    rst = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; vec0 = 0; vec1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",    {gnt0, gnt1}, 2'b00);
    check("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    check("rst_busy",   busy, 0);
    check("rst_wren",   mem_wren, 0);
    check("rst_vec",    mem_vec, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_data",   mem_data, 0);
    check("rst_rdata",  {rdata0, rdata1}, 0);
    rst = 0;

    // Table-driven contention sequence.
    we0 = 0; vec0 = 1; addr0 = 13'h040;
    we1 = 0; vec1 = 0; addr1 = 13'h080;
    for (int i = 0; i < 14; i++) begin
      step();
      req0 = tbl[i].r0;
      req1 = tbl[i].r1;
      @(negedge clk);
      check($sformatf("row%0d_gnt0", i),   gnt0,    tbl[i].e_g0);
      check($sformatf("row%0d_gnt1", i),   gnt1,    tbl[i].e_g1);
      check($sformatf("row%0d_busy", i),   busy,    tbl[i].e_busy);
      check($sformatf("row%0d_rv0", i),    rvalid0, tbl[i].e_rv0);
      check($sformatf("row%0d_rv1", i),    rvalid1, tbl[i].e_rv1);
      check($sformatf("row%0d_wren", i),   mem_wren, 0);
    end
    for (int i = 0; i < LANES; i++) exp_l[i] = {16'h0, pat(13'h040 + i)};
    check("cont_rdata0", rdata0, exp_l);
    exp_l = '0;
    exp_l[0] = {16'h0, pat(13'h080)};
    check("cont_rdata1", rdata1, exp_l);
    step();

    // Vector write then read at 0x100.
    for (int i = 0; i < LANES; i++) wd[i] = 32'hABCD_0000 | 32'(i + 1);
    wr_0 = n_wren; rv0_0 = n_rv0; rv1_0 = n_rv1;
    issue(0, 1, 1, 13'h100, wd);
    check("vw_wren",  mem_wren, 1);
    check("vw_addr",  mem_addr, 13'h100);
    check("vw_vec",   mem_vec, 1);
    check("vw_data",  mem_data, wd);
    step();
    @(negedge clk);
    check("vw_after_wren", mem_wren, 0);
    check("vw_after_busy", busy, 0);
    check("vw_wren_cycles", n_wren - wr_0, 1);
    step();
    issue(0, 0, 1, 13'h100, '0);
    wait_rv(0, lat);
    check("vr_latency", lat, 4);
    for (int i = 0; i < LANES; i++) exp_l[i] = 32'(i + 1);
    check("vr_rdata0", rdata0, exp_l);
    check("vw_no_rv_write", n_rv0 - rv0_0, 1);
    check("vr_no_rv1", n_rv1 - rv1_0, 0);

    // Scalar write (replication) then scalar read at 0x020.
    for (int i = 0; i < LANES; i++) wd[i] = 32'hDEAD_0000 | 32'(i);
    wd[0] = 32'h0000_BEEF;
    rv0_0 = n_rv0;
    issue(1, 1, 0, 13'h020, wd);
    for (int i = 0; i < LANES; i++) exp_l[i] = 32'h0000_BEEF;
    check("sw_data_repl", mem_data, exp_l);
    check("sw_vec", mem_vec, 0);
    check("sw_wren", mem_wren, 1);
    step();
    issue(1, 0, 0, 13'h020, '0);
    wait_rv(1, lat);
    check("sr_latency", lat, 4);
    check("sr_lane0", rdata1[0], 32'h0000_BEEF);
    check("sr_no_rv0", n_rv0 - rv0_0, 0);

    // Back-to-back writes from requester 0: a grant every other cycle.
    wr_0 = n_wren; rv0_0 = n_rv0;
    req0 = 1; we0 = 1; vec0 = 1; addr0 = 13'h300; wdata0 = wd;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_gnt0_c%0d", k), gnt0, (k % 2) == 0);
      step();
    end
    req0 = 0;
    step();
    check("b2b_writes", n_wren - wr_0, 3);
    check("b2b_no_rv0", n_rv0 - rv0_0, 0);

    // Address wrap: vector read at the top of the address space.
    issue(0, 0, 1, 13'h1FF8, '0);
    check("wrap_addr", mem_addr, 13'h1FF8);
    wait_rv(0, lat);
    check("wrap_latency", lat, 4);
    for (int i = 0; i < LANES; i++) exp_l[i] = {16'h0, pat((13'h1FF8 + i) & 13'h1FFF)};
    check("wrap_rdata0", rdata0, exp_l);

    // Reset during a write ACCESS drops mem_wren immediately.
    issue(0, 1, 1, 13'h400, wd);
    check("rw_wren_before", mem_wren, 1);
    #1 rst = 1;
    #1;
    check("rw_wren_reset", mem_wren, 0);
    check("rw_busy_reset", busy, 0);
    step();
    rst = 0;
    step();

    // Reset during WAIT of a requester-1 read: no rvalid, priority back to 0.
    rv1_0 = n_rv1;
    issue(1, 0, 1, 13'h500, '0);
    step();
    check("rr_busy_wait", busy, 1);
    rst = 1;
    #1;
    check("rr_busy_reset", busy, 0);
    step();
    rst = 0;
    repeat (6) step();
    check("rr_no_rv1", n_rv1 - rv1_0, 0);
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; vec0 = 1; vec1 = 1;
    addr0 = 13'h040; addr1 = 13'h080;
    @(negedge clk);
    check("rr_tie_gnt", {gnt0, gnt1}, 2'b10);
    step();
    req0 = 0; req1 = 0;
    @(negedge clk);
    wait_rv(0, lat);
    check("rr_next_latency", lat, 4);

    check("no_gnt_while_busy", n_gnt_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of mem_control, the 16-bank, 16-bit-per-bank vector/scalar memory.
- Accepts one access at a time from requester 0 (vector unit) or requester 1 (scalar/load path) using round-robin priority.
- Drives mem_control's address, data, write-enable and vec_scalar inputs for exactly one access cycle.
- Counts the fixed read latency and returns read data only to the requester that issued the read.

Parameters:
- ADDR_W, 13, memory address width; matches mem_control address.
- LANES, 16, vector lanes; one per RAM bank.
- RD_LAT, 2, number of clock edges from the ACCESS-cycle address to valid mem_q; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request; held by the requester until granted
- we0 / we1  in  1  1 = write, 0 = read
- vec0 / vec1  in  1  1 = vector access (16 lanes), 0 = scalar access (lane 0)
- addr0 / addr1  in  ADDR_W  base address
- wdata0 / wdata1  in  LANES x 32  write data
- gnt0 / gnt1  out  1  single-cycle acceptance pulse
- rvalid0 / rvalid1  out  1  single-cycle read-data-valid pulse
- rdata0 / rdata1  out  LANES x 32  read data; held between pulses
- busy  out  1  high when the state is not IDLE
- mem_addr  out  ADDR_W  to mem_control address
- mem_data  out  LANES x 32  to mem_control data
- mem_wren  out  1  to mem_control wren
- mem_vec  out  1  to mem_control vec_scalar
- mem_q  in  LANES x 32  from mem_control q

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- State machine: IDLE, ACCESS, WAIT.
- IDLE, at least one request high:
  - Select a winner.
  - Drive gnt of the winner high combinationally in the same cycle.
  - At the clock edge, latch the winner's we, vec, addr and wdata plus the winner id, then go to ACCESS.
- Round-robin: when both requests are high, the requester not granted last wins. After reset, requester 0 has priority.
- A request dropped before its grant has no effect. gnt is never high outside IDLE.
- ACCESS lasts exactly one cycle:
  - mem_addr, mem_vec and mem_data come from the latched command.
  - mem_wren equals the latched we.
  - Write: next state is IDLE; the write is complete. A write grant can follow every 2 cycles.
  - Read: load the latency counter with RD_LAT and go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, mem_q is captured into rdata of the issuing requester, and the next state is IDLE.
  - rvalid of that requester pulses in the following cycle, which is also the first IDLE cycle. A new grant is allowed in that same cycle.
- Latency with RD_LAT=2: gnt in t0, ACCESS in t1, capture in t3, rvalid in t4.
- Scalar writes replicate lane 0 of wdata onto all LANES lanes of mem_data, so any bank mapping mem_control uses for scalar stores receives the correct value.
- Upper 16 bits of each lane pass through unchanged. mem_control stores only bits 15:0 and returns zeros in bits 31:16.
- Scalar reads return the full mem_q; the consumer uses lane 0.
- mem_wren is 0 in every state except ACCESS-write. mem_addr, mem_data and mem_vec hold the last latched values outside ACCESS.
- Address overflow: mem_control adds lane offsets modulo 2^ADDR_W. The arbiter passes the base address unmodified and performs no range check.
- Reset values: gnt, rvalid, mem_wren, busy and mem_vec are 0; mem_addr, mem_data and both rdata are 0; state is IDLE; round-robin pointer favours requester 0.
- Reset asserted mid-operation: an in-flight read is discarded with no rvalid pulse; a write in ACCESS is aborted because mem_wren drops immediately.
- No rvalid is ever issued for a write.

Test Plan:
- Vector write then read: req0 with we=1, vec=1, addr=0x100, lane i=i+1, then a read at 0x100 -> gnt0 at t0, mem_wren high for exactly one cycle; the read rvalid0 arrives 4 cycles after its gnt with lane i = i+1 and bits 31:16 = 0.
- Scalar write: req1 with we=1, vec=0, addr=0x020, lane 0=0xBEEF -> every mem_data lane = 0xBEEF and mem_vec=0; a later scalar read at 0x020 returns lane 0 = 0xBEEF on rvalid1 only.
- Contention: req0 and req1 both held high for reads -> grants alternate 0,1,0,1; each rvalid goes only to its own requester; no grant while busy=1.
- Back-to-back writes from req0 -> gnt0 every 2 cycles; rvalid0 never asserts.
- Reset during WAIT of a read by req1 -> state returns to IDLE; rvalid1 stays 0; the next simultaneous request is granted to requester 0.
- Address wrap: vector read at 0x1FF8 -> mem_addr = 0x1FF8; rvalid0 arrives after 4 cycles with the data mem_control returns for the wrapped bank addresses.
